// File: rtl/adc_segment_sequencer.sv
// adc_segment_sequencer
//
// Decides which ADC sample cycles are written into the sample FIFO for
// single-shot and multi-segment captures, and reports per-segment and
// completion status. Everything runs in the adc_sampleclk domain.
//
// Ports:
//   adc_sampleclk              sole clock
//   reset                      synchronous, active-high
//   arm_i                      level, already synchronised arm command
//   trigger_i                  level, rising edge is the trigger event
//   offset_i                   cycles from trigger edge to first capture
//   samples_i                  samples per segment (0 behaves as 1)
//   num_segments_i             segments per capture (0 behaves as 1)
//   segment_cycles_i           segment period, first sample to first sample
//   segment_cycle_counter_en_i 1 = later segments timed, 0 = each waits for trigger
//   fifo_full_i                FIFO cannot accept a write
//   capture_o                  FIFO write enable for the current sample
//   segment_start_o            pulse on the first capture cycle of a segment
//   seg_index_o                index of the current or last segment
//   armed_o                    armed and waiting for a trigger
//   capture_done_o             capture finished, held until disarm
//   overflow_o                 sticky, FIFO was full while capturing
//   last_trig_delta_o          cycles between trigger-initiated segment starts
//
// Optional feature macro: SEGMENT_TRIG_TIMESTAMP_EN enables the trigger
// timestamp counter behind last_trig_delta_o; otherwise that output is 0.

module adc_segment_sequencer #(
  parameter int pSEG_W  = 16,
  parameter int pCYC_W  = 20,
  parameter int pSAMP_W = 32
) (
  input  logic               adc_sampleclk,
  input  logic               reset,
  input  logic               arm_i,
  input  logic               trigger_i,
  input  logic [pSAMP_W-1:0] offset_i,
  input  logic [pSAMP_W-1:0] samples_i,
  input  logic [pSEG_W-1:0]  num_segments_i,
  input  logic [pCYC_W-1:0]  segment_cycles_i,
  input  logic               segment_cycle_counter_en_i,
  input  logic               fifo_full_i,
  output logic               capture_o,
  output logic               segment_start_o,
  output logic [pSEG_W-1:0]  seg_index_o,
  output logic               armed_o,
  output logic               capture_done_o,
  output logic               overflow_o,
  output logic [31:0]        last_trig_delta_o
);

  localparam logic [pSAMP_W-1:0] SAMP_ONE = {{(pSAMP_W-1){1'b0}}, 1'b1};
  localparam logic [pCYC_W-1:0]  CYC_ONE  = {{(pCYC_W-1){1'b0}}, 1'b1};
  localparam logic [pSEG_W-1:0]  SEG_ONE  = {{(pSEG_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, WAIT_TRIG, OFFSET, CAPTURE, GAP, DONE
  } state_t;

  state_t state, next_state;

  logic               trig_r, arm_r;
  logic               trig_edge, arm_edge;
  logic [pSAMP_W-1:0] cfg_offset, cfg_samples;
  logic [pSEG_W-1:0]  cfg_segments;
  logic [pCYC_W-1:0]  cfg_cycles;
  logic               cfg_cycle_mode;
  logic [pSAMP_W-1:0] off_cnt, sample_cnt;
  logic [pCYC_W-1:0]  period_cnt;
  logic [pSEG_W-1:0]  seg_index;
  logic               overflow;
  logic               start_seg, seg_end, last_seg, back_to_back;

  assign trig_edge = trigger_i & ~trig_r;
  assign arm_edge  = arm_i & ~arm_r;

  // Segment bookkeeping. The period counter reads 0 on the first capture
  // cycle, so the next segment is due once it reaches segment_cycles-1.
  assign seg_end      = (sample_cnt == cfg_samples - SAMP_ONE);
  assign last_seg     = (({1'b0, seg_index} + {1'b0, SEG_ONE}) == {1'b0, cfg_segments});
  assign back_to_back = ({{pSAMP_W{1'b0}}, cfg_cycles} <= {{pCYC_W{1'b0}}, cfg_samples});

  // Next-state logic. Disarm is tested first in every active state so it
  // wins over triggers, segment ends and FIFO-full. start_seg marks the
  // cycle before a segment's first capture cycle so the counters restart.
  always_comb begin
    next_state = state;
    start_seg  = 1'b0;
    case (state)
      IDLE: begin
        if (arm_edge) next_state = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (!arm_i) next_state = IDLE;
        else if (trig_edge) begin
          if (cfg_offset != '0) next_state = OFFSET;
          else begin
            next_state = CAPTURE;
            start_seg  = 1'b1;
          end
        end
      end
      OFFSET: begin
        if (!arm_i) next_state = IDLE;
        else if (off_cnt == '0) begin
          next_state = CAPTURE;
          start_seg  = 1'b1;
        end
      end
      CAPTURE: begin
        if (!arm_i) next_state = IDLE;
        else if (fifo_full_i) next_state = DONE;
        else if (seg_end) begin
          if (last_seg) next_state = DONE;
          else if (!cfg_cycle_mode) next_state = WAIT_TRIG;
          else if (back_to_back) begin
            next_state = CAPTURE;
            start_seg  = 1'b1;
          end else next_state = GAP;
        end
      end
      GAP: begin
        if (!arm_i) next_state = IDLE;
        else if (period_cnt == cfg_cycles - CYC_ONE) begin
          next_state = CAPTURE;
          start_seg  = 1'b1;
        end
      end
      DONE: begin
        if (!arm_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State, edge-detect, configuration latch and counters. All counters hold
  // at their terminal value rather than wrapping.
  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      state          <= IDLE;
      trig_r         <= 1'b0;
      arm_r          <= 1'b0;
      cfg_offset     <= '0;
      cfg_samples    <= '0;
      cfg_segments   <= '0;
      cfg_cycles     <= '0;
      cfg_cycle_mode <= 1'b0;
      off_cnt        <= '0;
      sample_cnt     <= '0;
      period_cnt     <= '0;
      seg_index      <= '0;
      overflow       <= 1'b0;
    end else begin
      state  <= next_state;
      trig_r <= trigger_i;
      arm_r  <= arm_i;

      if (state == IDLE && arm_edge) begin
        cfg_offset     <= offset_i;
        cfg_samples    <= (samples_i == '0) ? SAMP_ONE : samples_i;
        cfg_segments   <= (num_segments_i == '0) ? SEG_ONE : num_segments_i;
        cfg_cycles     <= segment_cycles_i;
        cfg_cycle_mode <= segment_cycle_counter_en_i;
        seg_index      <= '0;
        overflow       <= 1'b0;
      end

      if (state == WAIT_TRIG && next_state == OFFSET)
        off_cnt <= cfg_offset - SAMP_ONE;
      else if (state == OFFSET && off_cnt != '0)
        off_cnt <= off_cnt - SAMP_ONE;

      if (start_seg) begin
        sample_cnt <= '0;
        period_cnt <= '0;
      end else begin
        if (state == CAPTURE && sample_cnt != '1) sample_cnt <= sample_cnt + SAMP_ONE;
        if (period_cnt != '1) period_cnt <= period_cnt + CYC_ONE;
      end

      // A segment that ends on a FIFO-full cycle still counts as ended.
      if (state == CAPTURE && arm_i) begin
        if (fifo_full_i) overflow <= 1'b1;
        if (seg_end && seg_index != '1) seg_index <= seg_index + SEG_ONE;
      end
    end
  end

  assign capture_o       = (state == CAPTURE) & arm_i & ~fifo_full_i;
  assign segment_start_o = (state == CAPTURE) & arm_i & (sample_cnt == '0);
  assign armed_o         = (state == WAIT_TRIG);
  assign capture_done_o  = (state == DONE);
  assign seg_index_o     = seg_index;
  assign overflow_o      = overflow;

`ifdef SEGMENT_TRIG_TIMESTAMP_EN
  logic        trig_start;
  logic        ts_seen;
  logic [31:0] ts_cnt, ts_next, last_delta;

  // ts_cnt reads 0 on a trigger-initiated first capture cycle; the delta is
  // sampled on the cycle before the next one, hence the +1.
  assign trig_start = (state == WAIT_TRIG || state == OFFSET) && next_state == CAPTURE;
  assign ts_next    = (ts_cnt == 32'hFFFF_FFFF) ? ts_cnt : ts_cnt + 32'd1;

  always_ff @(posedge adc_sampleclk) begin
    if (reset) begin
      ts_cnt     <= '0;
      ts_seen    <= 1'b0;
      last_delta <= '0;
    end else if (state == IDLE && arm_edge) begin
      ts_cnt     <= '0;
      ts_seen    <= 1'b0;
      last_delta <= '0;
    end else if (trig_start) begin
      if (ts_seen) last_delta <= ts_next;
      ts_seen <= 1'b1;
      ts_cnt  <= '0;
    end else begin
      ts_cnt <= ts_next;
    end
  end

  assign last_trig_delta_o = last_delta;
`else
  assign last_trig_delta_o = '0;
`endif

endmodule

// File: tb/tb_adc_segment_sequencer.sv
// tb_adc_segment_sequencer
//
// Drives adc_segment_sequencer with directed and randomised capture
// scenarios. Expected outputs come from an interval-level reference model
// that places segments on a cycle timeline from the configuration and the
// trigger / FIFO-full schedules.
//
// Optional feature macro: SEGMENT_TRIG_TIMESTAMP_EN (also selects the
// expected last_trig_delta_o values).

module tb_adc_segment_sequencer;

  localparam int LEN = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm_i, trigger_i, fifo_full_i;
  logic [31:0] offset_i, samples_i;
  logic [15:0] num_segments_i;
  logic [19:0] segment_cycles_i;
  logic        segment_cycle_counter_en_i;
  logic        capture_o, segment_start_o, armed_o, capture_done_o, overflow_o;
  logic [15:0] seg_index_o;
  logic [31:0] last_trig_delta_o;

  int tests = 0;
  int fails = 0;

  // Stimulus schedules and configuration for one scenario
  bit trig_a[LEN];
  bit full_a[LEN];
  int raw_off, raw_samp, raw_segs, raw_cyc;
  bit raw_mode;
  int c_off, c_samp, c_segs, c_cyc;
  bit c_mode;

  // Expected per-cycle outputs
  bit          e_cap[LEN], e_ss[LEN], e_armed[LEN], e_done[LEN], e_ovf[LEN];
  int          e_idx[LEN];
  logic [31:0] e_delta[LEN];

  // Observed summary of the last scenario
  int obs_first_cap, obs_last_cap, obs_cap_count, obs_ss_count, obs_first_done;

  adc_segment_sequencer dut (
    .adc_sampleclk              (clk),
    .reset                      (reset),
    .arm_i                      (arm_i),
    .trigger_i                  (trigger_i),
    .offset_i                   (offset_i),
    .samples_i                  (samples_i),
    .num_segments_i             (num_segments_i),
    .segment_cycles_i           (segment_cycles_i),
    .segment_cycle_counter_en_i (segment_cycle_counter_en_i),
    .fifo_full_i                (fifo_full_i),
    .capture_o                  (capture_o),
    .segment_start_o            (segment_start_o),
    .seg_index_o                (seg_index_o),
    .armed_o                    (armed_o),
    .capture_done_o             (capture_done_o),
    .overflow_o                 (overflow_o),
    .last_trig_delta_o          (last_trig_delta_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's control inputs, then move to the sampling point.
  task automatic applyStimulus(input bit a, input bit t, input bit f);
    arm_i       = a;
    trigger_i   = t;
    fifo_full_i = f;
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    arm_i       = 1'b0;
    trigger_i   = 1'b0;
    fifo_full_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic setConfig(input int off, input int samp, input int segs, input int cyc, input bit mode);
    raw_off  = off;
    raw_samp = samp;
    raw_segs = segs;
    raw_cyc  = cyc;
    raw_mode = mode;
    c_off    = off;
    c_samp   = (samp == 0) ? 1 : samp;
    c_segs   = (segs == 0) ? 1 : segs;
    c_cyc    = cyc;
    c_mode   = mode;
    offset_i                   = 32'(off);
    samples_i                  = 32'(samp);
    num_segments_i             = 16'(segs);
    segment_cycles_i           = 20'(cyc);
    segment_cycle_counter_en_i = mode;
  endtask

  task automatic clearStim();
    for (int k = 0; k < LEN; k++) begin
      trig_a[k] = 1'b0;
      full_a[k] = 1'b0;
    end
  endtask

  // Reference model: arm edge in cycle 0, waiting from cycle 1. Each
  // capture run starts one cycle after a trigger rise plus the offset;
  // segments then chain by period (or back-to-back) or wait for the next
  // trigger, until the segment count is reached or a FIFO-full aborts.
  task automatic buildExpected();
    int w, c, start, ts_prev, ovf_at, done_at, segs_done, t, running;
    bit finished, chain;
    int inc[LEN];
    for (int k = 0; k < LEN; k++) begin
      e_cap[k] = 0; e_ss[k] = 0; e_armed[k] = 0; e_done[k] = 0; e_ovf[k] = 0;
      e_idx[k] = 0; e_delta[k] = 0; inc[k] = 0;
    end
    w = 1; ts_prev = -1; ovf_at = -1; done_at = -1; segs_done = 0; finished = 0;
    while (!finished) begin
      c = -1;
      for (int k = w; k < LEN && c < 0; k++)
        if (trig_a[k] && (k == 0 || !trig_a[k-1])) c = k;
      for (int k = w; k < ((c < 0) ? LEN : c + 1); k++) e_armed[k] = 1;
      if (c < 0) finished = 1;
      else begin
        start = c + 1 + c_off;
`ifdef SEGMENT_TRIG_TIMESTAMP_EN
        if (ts_prev >= 0)
          for (int k = start; k < LEN; k++) e_delta[k] = 32'(start - ts_prev);
`endif
        ts_prev = start;
        chain = 1;
        while (chain) begin
          for (int i = 0; i < c_samp && !finished; i++) begin
            t = start + i;
            if (t >= LEN) finished = 1;
            else begin
              if (i == 0) e_ss[t] = 1;
              if (i == c_samp - 1) begin
                segs_done++;
                if (t + 1 < LEN) inc[t+1] = 1;
              end
              if (full_a[t]) begin
                ovf_at = t + 1;
                done_at = t + 1;
                finished = 1;
              end else e_cap[t] = 1;
            end
          end
          if (finished) chain = 0;
          else if (segs_done == c_segs) begin
            done_at = start + c_samp;
            finished = 1;
            chain = 0;
          end else if (c_mode) start = (c_cyc <= c_samp) ? start + c_samp : start + c_cyc;
          else begin
            w = start + c_samp;
            chain = 0;
          end
        end
      end
    end
    running = 0;
    for (int k = 0; k < LEN; k++) begin
      running += inc[k];
      e_idx[k] = running;
      e_ovf[k]  = (ovf_at >= 0 && k >= ovf_at);
      e_done[k] = (done_at >= 0 && k >= done_at);
    end
  endtask

  task automatic runScenario(input string name);
    doReset();
    buildExpected();
    obs_first_cap = -1; obs_last_cap = -1; obs_cap_count = 0; obs_ss_count = 0; obs_first_done = -1;
    for (int k = 0; k < LEN; k++) begin
      if (k > 0) begin
        offset_i                   = $urandom;
        samples_i                  = $urandom;
        num_segments_i             = 16'($urandom);
        segment_cycles_i           = 20'($urandom);
        segment_cycle_counter_en_i = 1'($urandom);
      end
      applyStimulus(1'b1, trig_a[k], full_a[k]);
      checkOutput($sformatf("%s cap@%0d", name, k), 32'(capture_o), 32'(e_cap[k]));
      checkOutput($sformatf("%s ss@%0d", name, k), 32'(segment_start_o), 32'(e_ss[k]));
      checkOutput($sformatf("%s armed@%0d", name, k), 32'(armed_o), 32'(e_armed[k]));
      checkOutput($sformatf("%s done@%0d", name, k), 32'(capture_done_o), 32'(e_done[k]));
      checkOutput($sformatf("%s ovf@%0d", name, k), 32'(overflow_o), 32'(e_ovf[k]));
      checkOutput($sformatf("%s idx@%0d", name, k), 32'(seg_index_o), 32'(e_idx[k]));
      checkOutput($sformatf("%s delta@%0d", name, k), last_trig_delta_o, e_delta[k]);
      if (capture_o) begin
        if (obs_first_cap < 0) obs_first_cap = k;
        obs_last_cap = k;
        obs_cap_count++;
      end
      if (segment_start_o) obs_ss_count++;
      if (capture_done_o && obs_first_done < 0) obs_first_done = k;
      nextCycle();
    end
    arm_i = 1'b0;
  endtask

  task automatic directedScenarios();
    // single segment, trigger rises in cycle 10
    clearStim(); setConfig(0, 8, 1, 0, 0);
    for (int k = 10; k < 14; k++) trig_a[k] = 1;
    runScenario("single");
    checkOutput("single first_cap", 32'(obs_first_cap), 32'd11);
    checkOutput("single cap_count", 32'(obs_cap_count), 32'd8);
    checkOutput("single first_done", 32'(obs_first_done), 32'd19);
    checkOutput("single seg_index", 32'(seg_index_o), 32'd1);

    // offset 5 with triggers during OFFSET and CAPTURE
    clearStim(); setConfig(5, 4, 1, 0, 0);
    trig_a[20] = 1; trig_a[23] = 1; trig_a[27] = 1; trig_a[28] = 1;
    runScenario("offset");
    checkOutput("offset first_cap", 32'(obs_first_cap), 32'd26);
    checkOutput("offset cap_count", 32'(obs_cap_count), 32'd4);

    // cycle-timed segments with a gap
    clearStim(); setConfig(0, 4, 3, 10, 1);
    trig_a[10] = 1;
    runScenario("timed");
    checkOutput("timed cap_count", 32'(obs_cap_count), 32'd12);
    checkOutput("timed ss_count", 32'(obs_ss_count), 32'd3);
    checkOutput("timed first_done", 32'(obs_first_done), 32'd35);

    // period shorter than a segment: back-to-back
    clearStim(); setConfig(0, 4, 3, 2, 1);
    trig_a[10] = 1;
    runScenario("b2b");
    checkOutput("b2b first_cap", 32'(obs_first_cap), 32'd11);
    checkOutput("b2b last_cap", 32'(obs_last_cap), 32'd22);
    checkOutput("b2b cap_count", 32'(obs_cap_count), 32'd12);

    // one trigger per segment, triggers 100 cycles apart
    clearStim(); setConfig(0, 3, 2, 0, 0);
    trig_a[10] = 1; trig_a[110] = 1;
    runScenario("pertrig");
    checkOutput("pertrig cap_count", 32'(obs_cap_count), 32'd6);
`ifdef SEGMENT_TRIG_TIMESTAMP_EN
    checkOutput("pertrig delta", last_trig_delta_o, 32'd100);
`else
    checkOutput("pertrig delta", last_trig_delta_o, 32'd0);
`endif

    // FIFO full on the 2nd sample of the first of three segments
    clearStim(); setConfig(0, 4, 3, 10, 1);
    trig_a[10] = 1; full_a[12] = 1;
    runScenario("full");
    checkOutput("full cap_count", 32'(obs_cap_count), 32'd1);
    checkOutput("full first_done", 32'(obs_first_done), 32'd13);
    checkOutput("full overflow", 32'(overflow_o), 32'd1);
    checkOutput("full seg_index", 32'(seg_index_o), 32'd0);
  endtask

  task automatic randomScenarios(input int count);
    bit level, use_full;
    for (int n = 0; n < count; n++) begin
      setConfig($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 4),
                $urandom_range(0, 12), 1'($urandom_range(0, 1)));
      level = 0;
      use_full = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < LEN; k++) begin
        if ($urandom_range(0, 5) == 0) level = ~level;
        trig_a[k] = level;
        full_a[k] = use_full && ($urandom_range(0, 39) == 0);
      end
      runScenario($sformatf("rand%0d", n));
    end
  endtask

  task automatic disarmAndResetTests();
    // disarm while in GAP
    doReset(); setConfig(0, 2, 3, 8, 1);
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 0, 0); checkOutput("gap armed", 32'(armed_o), 32'd1); nextCycle();
    applyStimulus(1, 1, 0); nextCycle();
    applyStimulus(1, 1, 0); checkOutput("gap ss", 32'(segment_start_o), 32'd1); nextCycle();
    applyStimulus(1, 0, 0); checkOutput("gap cap2", 32'(capture_o), 32'd1); nextCycle();
    applyStimulus(1, 0, 0); checkOutput("gap idx", 32'(seg_index_o), 32'd1); nextCycle();
    applyStimulus(0, 0, 0); checkOutput("gap disarm cap", 32'(capture_o), 32'd0); nextCycle();
    applyStimulus(0, 0, 0);
    checkOutput("gap idle armed", 32'(armed_o), 32'd0);
    checkOutput("gap idle done", 32'(capture_done_o), 32'd0);
    checkOutput("gap idle idx", 32'(seg_index_o), 32'd1);
    nextCycle();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("gap idle cap%0d", k), 32'(capture_o), 32'd0);
      nextCycle();
    end

    // disarm in CAPTURE suppresses that cycle's write
    doReset(); setConfig(0, 6, 1, 0, 0);
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 1, 0); nextCycle();
    applyStimulus(1, 1, 0); checkOutput("cdis cap", 32'(capture_o), 32'd1); nextCycle();
    applyStimulus(0, 1, 0); checkOutput("cdis cap_off", 32'(capture_o), 32'd0); nextCycle();
    applyStimulus(0, 0, 0);
    checkOutput("cdis idle cap", 32'(capture_o), 32'd0);
    checkOutput("cdis idle armed", 32'(armed_o), 32'd0);
    nextCycle();

    // overflow survives disarm, re-arm clears it
    doReset(); setConfig(0, 5, 3, 0, 0);
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 1, 0); nextCycle();
    applyStimulus(1, 0, 0); checkOutput("ovf cap", 32'(capture_o), 32'd1); nextCycle();
    applyStimulus(1, 0, 1); checkOutput("ovf cap_full", 32'(capture_o), 32'd0); nextCycle();
    applyStimulus(1, 0, 0);
    checkOutput("ovf set", 32'(overflow_o), 32'd1);
    checkOutput("ovf done", 32'(capture_done_o), 32'd1);
    nextCycle();
    applyStimulus(0, 0, 0); nextCycle();
    applyStimulus(0, 0, 0);
    checkOutput("ovf kept", 32'(overflow_o), 32'd1);
    checkOutput("ovf done_clr", 32'(capture_done_o), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 0, 0);
    checkOutput("rearm ovf_clr", 32'(overflow_o), 32'd0);
    checkOutput("rearm armed", 32'(armed_o), 32'd1);
    nextCycle();

    // synchronous reset during CAPTURE
    doReset(); setConfig(2, 4, 1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("rst cap", 32'(capture_o), 32'd0);
    checkOutput("rst armed", 32'(armed_o), 32'd0);
    checkOutput("rst done", 32'(capture_done_o), 32'd0);
    checkOutput("rst ovf", 32'(overflow_o), 32'd0);
    checkOutput("rst idx", 32'(seg_index_o), 32'd0);
    nextCycle();
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 1, 0); nextCycle();
    applyStimulus(1, 1, 0); checkOutput("rst offset1", 32'(capture_o), 32'd0); nextCycle();
    applyStimulus(1, 1, 0); checkOutput("rst offset2", 32'(capture_o), 32'd0); nextCycle();
    applyStimulus(1, 0, 0); checkOutput("rst pre cap", 32'(capture_o), 32'd1); nextCycle();
    reset = 1'b1;
    applyStimulus(1, 0, 0); nextCycle();
    applyStimulus(1, 0, 0);
    checkOutput("rst mid cap", 32'(capture_o), 32'd0);
    checkOutput("rst mid ss", 32'(segment_start_o), 32'd0);
    checkOutput("rst mid armed", 32'(armed_o), 32'd0);
    checkOutput("rst mid done", 32'(capture_done_o), 32'd0);
    checkOutput("rst mid ovf", 32'(overflow_o), 32'd0);
    checkOutput("rst mid idx", 32'(seg_index_o), 32'd0);
    checkOutput("rst mid delta", last_trig_delta_o, 32'd0);
    nextCycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    arm_i = 1'b0; trigger_i = 1'b0; fifo_full_i = 1'b0;
    setConfig(0, 0, 0, 0, 0);
    directedScenarios();
    disarmAndResetTests();
    randomScenarios(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_segment_sequencer.md
Name: adc_segment_sequencer

Overview:
Sequences ADC sample capture into the sample FIFO for single-shot and multi-segment captures. Sits in the adc_sampleclk domain between the register block (cmd_arm_adc, trigger_offset, maxsamples, num_segments, segment_cycles, segment_cycle_counter_en) and the FIFO write port. It decides which sample cycles are written and emits per-segment and completion status.

Parameters:
pSEG_W, 16, width of segment count and index.
pCYC_W, 20, width of segment period counter.
pSAMP_W, 32, width of sample count and offset.

Ports:
adc_sampleclk  in  1  sole clock
reset  in  1  synchronous, active-high
arm_i  in  1  level; already synchronised cmd_arm_adc
trigger_i  in  1  level; rising edge is the trigger event
offset_i  in  pSAMP_W  cycles from trigger edge to first capture
samples_i  in  pSAMP_W  samples per segment; 0 treated as 1
num_segments_i  in  pSEG_W  segments per capture; 0 treated as 1
segment_cycles_i  in  pCYC_W  segment period in cycles, first sample to first sample
segment_cycle_counter_en_i  in  1  1 = later segments timed by segment_cycles_i; 0 = each segment waits for a trigger
fifo_full_i  in  1  FIFO cannot accept a write
capture_o  out  1  FIFO write enable for the current ADC sample
segment_start_o  out  1  one-cycle pulse on the first capture cycle of each segment
seg_index_o  out  pSEG_W  index of the current or last segment
armed_o  out  1  armed and waiting for a trigger
capture_done_o  out  1  capture finished; held until disarm
overflow_o  out  1  sticky; FIFO was full during CAPTURE
last_trig_delta_o  out  32  see Optional Feature

Behaviour:
- Clock and reset: single clock adc_sampleclk; reset is synchronous, active-high.
- Reset: state=IDLE. All outputs are 0. Internal counters and trig_r are 0.
- Edge detect:
  - trig_r is trigger_i registered.
  - trig_edge = trigger_i & ~trig_r.
  - arm_edge is derived the same way from arm_i.
- Config latch:
  - On arm_edge in IDLE, latch offset_i, samples_i, num_segments_i, segment_cycles_i and segment_cycle_counter_en_i.
  - Apply the 0->1 substitution for samples and segments at latch time.
  - Input changes after arm have no effect until the next arm.
  - On arm_edge, clear seg_index_o, overflow_o and capture_done_o.
- States:
  - IDLE: arm_edge -> WAIT_TRIG.
  - WAIT_TRIG: armed_o=1. trig_edge -> OFFSET if offset!=0, else CAPTURE.
  - OFFSET: load counter with offset-1 on entry; -> CAPTURE when it reaches 0.
  - CAPTURE:
    - capture_o = 1 & ~fifo_full_i.
    - First cycle: segment_start_o=1; period counter cleared.
    - The sample counter ends the segment after samples cycles (last cycle included).
    - At segment end, seg_index_o increments (saturating at 2^pSEG_W-1).
    - Next state if seg_index+1 == segments: DONE.
    - Else if cycle mode is on: GAP.
    - Else: WAIT_TRIG.
  - GAP:
    - The period counter keeps running from the segment's first cycle.
    - Enter CAPTURE so that the next first-capture cycle = previous first-capture cycle + segment_cycles.
    - If segment_cycles <= samples, skip GAP: the next segment starts the cycle after the last sample (back-to-back, no trigger).
  - DONE: capture_done_o=1; stays until arm_i=0, then -> IDLE.
- Latency:
  - trigger_i first sampled high in cycle N (low in N-1) with offset=0: capture_o=1 in cycle N+1.
  - With offset K: capture_o=1 in cycle N+1+K.
- Ignored triggers: trig_edge is ignored in OFFSET, CAPTURE, GAP, DONE and IDLE.
- Disarm: arm_i=0 in any non-IDLE state -> IDLE next cycle; capture_o=0 in that cycle. overflow_o and seg_index_o are retained. capture_done_o clears.
- FIFO overflow: fifo_full_i=1 in CAPTURE sets overflow_o and suppresses capture_o. The state machine goes to DONE immediately, aborting the remaining segments.
- Simultaneous events:
  - reset dominates everything.
  - Disarm dominates trigger and segment end.
  - Segment end on the same cycle as fifo_full_i -> DONE with overflow_o=1.
- Counters never wrap: counts stop at their terminal value.
- Reset mid-operation: return to the reset state the next cycle.

Optional Feature:
Macro: SEGMENT_TRIG_TIMESTAMP_EN.
- Defined:
  - A 32-bit free-running counter restarts at 0 on each trigger-initiated segment start and saturates at 0xFFFFFFFF.
  - last_trig_delta_o latches the counter value on every trigger-initiated segment start after the first in a capture.
  - It is cleared on arm_edge.
- Undefined: last_trig_delta_o is tied to 0 and no counter logic is instantiated.

Test Plan:
- Single segment: arm, offset=0, samples=8, segments=1; trigger rises in cycle 10 -> capture_o high cycles 11-18, segment_start_o at 11, capture_done_o from 19, seg_index_o=1.
- Offset: offset=5, samples=4 -> capture_o cycles N+6..N+9; triggers during OFFSET/CAPTURE ignored.
- Cycle-timed segments: segments=3, samples=4, segment_cycles=10, cycle mode on -> segment_start_o at T, T+10, T+20, 12 capture cycles total, done after T+23. With segment_cycles=2: 12 contiguous capture cycles.
- Trigger-per-segment: segments=2, cycle mode off, samples=3; triggers 100 cycles apart -> two 3-cycle bursts. With the macro defined, last_trig_delta_o=100.
- FIFO full in the 2nd sample of segment 1 of 3 -> capture_o low that cycle, overflow_o=1, capture_done_o next cycle, seg_index_o=0.
- Disarm in GAP and synchronous reset in CAPTURE -> IDLE next cycle, capture_o=0. After reset, all outputs are 0. Re-arm clears overflow_o.
